fb_line_scheduler: RTL and testbench

FB_LINE_SCHEDULER -- requirements
Module: fb_line_scheduler

---
 rtl/fb_line_scheduler_pkg.sv | 20 ++
 rtl/shift_register.sv | 26 ++
 rtl/fb_line_scheduler.sv | 162 ++++++++++++++++
 tb/tb_fb_line_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_line_scheduler_pkg.sv
// Shared definitions for the framebuffer line scheduler: scheduler state
// encoding and the next-line helper used to pick the line to prefetch.
package fb_line_scheduler_pkg;

  localparam int FB_STATE_W = 2;

  typedef enum logic [FB_STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_YIELD = 2'd2,
    ST_DRAIN = 2'd3
  } fb_state_e;

  // The line being displayed next: wraps to 0 after the last line of the frame.
  function automatic logic [31:0] next_line(input logic [31:0] vc,
                                            input logic [31:0] max_v);
    return (vc == max_v) ? 32'd0 : vc + 32'd1;
  endfunction

endpackage

// File: rtl/shift_register.sv
// Fixed-delay register chain; every stage clears on reset so nothing
// in flight survives a reset.
module shift_register #(
  parameter int WIDTH = 1,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg_p [DELAY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DELAY; i++) stg_p[i] <= '0;
    end else begin
      stg_p[0] <= d;
      for (int i = 1; i < DELAY; i++) stg_p[i] <= stg_p[i-1];
    end
  end

  assign q = stg_p[DELAY-1];

endmodule

// File: rtl/fb_line_scheduler.sv
// Prefetches the next visible scanline from memory into a ping-pong line
// buffer, interleaving a single-word writer port between read bursts.
module fb_line_scheduler
  import fb_line_scheduler_pkg::*;
#(
  parameter int FB_WORDS    = 320,
  parameter int FB_LINES    = 720,
  parameter int FB_MAX_V    = 749,
  parameter int ADDR_BITS   = 20,
  parameter int DATA_BITS   = 32,
  parameter int BURST_LEN   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 vcount,
  input  logic                        vsync,
  input  logic [ADDR_BITS-1:0]        base_addr,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_BITS-1:0]        wr_addr,
  input  logic [DATA_BITS-1:0]        wr_data,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_BITS-1:0]        mem_addr,
  output logic [DATA_BITS-1:0]        mem_wdata,
  input  logic [DATA_BITS-1:0]        mem_rdata,
  output logic                        lb_we,
  output logic                        lb_bank,
  output logic [$clog2(FB_WORDS)-1:0] lb_addr,
  output logic [DATA_BITS-1:0]        lb_wdata,
  output logic                        overrun
);

  localparam int IDX_W = $clog2(FB_WORDS);
  localparam int BC_W  = $clog2(BURST_LEN + 1);
  localparam int LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int PIPE_W = IDX_W + 2;

  fb_state_e              state;
  logic [31:0]            vcount_q;
  logic                   vsync_q;
  logic [ADDR_BITS-1:0]   frame_base;
  logic [ADDR_BITS-1:0]   line_addr;
  logic [IDX_W-1:0]       word;
  logic [BC_W-1:0]        burst_cnt;
  logic [LAT_W-1:0]       drain_cnt;
  logic                   fetch_bank;
  logic                   overrun_q;

  logic [31:0]            target;
  logic                   line_evt;
  logic                   fetch_req;
  logic                   vsync_fall;
  logic [ADDR_BITS-1:0]   base_now;
  logic [ADDR_BITS-1:0]   line_start;
  logic                   last_word;
  logic                   burst_end;
  logic                   grant_ok;
  logic                   rd_issue;
  logic                   wr_issue;
  logic [PIPE_W-1:0]      pipe_d;
  logic [PIPE_W-1:0]      pipe_q;

  assign line_evt   = (vcount != vcount_q);
  assign target     = next_line(vcount, 32'(FB_MAX_V));
  assign fetch_req  = line_evt && (target < 32'(FB_LINES));
  assign vsync_fall = vsync_q && !vsync;

  // A base change landing on the same cycle as the line event must already apply.
  assign base_now   = vsync_fall ? base_addr : frame_base;
  assign line_start = base_now + ADDR_BITS'(target * 32'(FB_WORDS));

  assign last_word  = (word == IDX_W'(FB_WORDS - 1));
  assign burst_end  = (burst_cnt == BC_W'(BURST_LEN - 1));

  // Writer is served only in gaps the fetch leaves open; reads and writes never share a cycle.
  assign grant_ok  = (state == ST_YIELD) || ((state == ST_IDLE) && !fetch_req);
  assign rd_issue  = (state == ST_FETCH) && !reset;
  assign wr_issue  = grant_ok && wr_valid && !reset;

  assign wr_ready  = wr_issue;
  assign mem_en    = rd_issue || wr_issue;
  assign mem_we    = wr_issue;
  assign mem_addr  = wr_issue ? wr_addr : (line_addr + ADDR_BITS'(word));
  assign mem_wdata = wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      vcount_q   <= '0;
      vsync_q    <= 1'b1;
      frame_base <= '0;
      line_addr  <= '0;
      word       <= '0;
      burst_cnt  <= '0;
      drain_cnt  <= '0;
      fetch_bank <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      vcount_q <= vcount;
      vsync_q  <= vsync;
      if (vsync_fall) frame_base <= base_addr;

      if (fetch_req) begin
        // Any fetch still in progress is abandoned; its in-flight reads still land.
        if (state != ST_IDLE) overrun_q <= 1'b1;
        state      <= ST_FETCH;
        word       <= '0;
        burst_cnt  <= '0;
        line_addr  <= line_start;
        fetch_bank <= target[0];
      end else begin
        case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_FETCH: begin
            if (last_word) begin
              state     <= ST_DRAIN;
              word      <= '0;
              burst_cnt <= '0;
              drain_cnt <= LAT_W'(MEM_LATENCY - 1);
            end else begin
              word <= word + IDX_W'(1);
              if (burst_end) begin
                burst_cnt <= '0;
                if (wr_valid) state <= ST_YIELD;
              end else begin
                burst_cnt <= burst_cnt + BC_W'(1);
              end
            end
          end
          ST_YIELD: state <= ST_FETCH;
          ST_DRAIN: begin
            if (drain_cnt == '0) state <= ST_IDLE;
            else                 drain_cnt <= drain_cnt - LAT_W'(1);
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Read valid, bank and word index travel with the memory latency.
  assign pipe_d = {rd_issue, fetch_bank, word};

  shift_register #(
    .WIDTH (PIPE_W),
    .DELAY (MEM_LATENCY)
  ) u_rd_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (pipe_d),
    .q     (pipe_q)
  );

  assign lb_we    = pipe_q[PIPE_W-1];
  assign lb_bank  = pipe_q[PIPE_W-2];
  assign lb_addr  = pipe_q[IDX_W-1:0];
  assign lb_wdata = mem_rdata;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_fb_line_scheduler.sv
// Directed and randomized bench for fb_line_scheduler against a
// transaction-level model of the line fetch schedule and a fixed-latency memory.
module tb_fb_line_scheduler;

  localparam int W     = 8;
  localparam int BL    = 4;
  localparam int LINES = 720;
  localparam int MAXV  = 749;
  localparam int LAT   = 2;
  localparam int AB    = 20;
  localparam int DB    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   vcount = '0;
  logic          vsync = 1'b1;
  logic [AB-1:0] base_addr = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AB-1:0] wr_addr = '0;
  logic [DB-1:0] wr_data = '0;
  logic          mem_en, mem_we;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_wdata, mem_rdata;
  logic          lb_we, lb_bank, overrun;
  logic [2:0]    lb_addr;
  logic [DB-1:0] lb_wdata;

  fb_line_scheduler #(
    .FB_WORDS(W), .FB_LINES(LINES), .FB_MAX_V(MAXV), .ADDR_BITS(AB),
    .DATA_BITS(DB), .BURST_LEN(BL), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .vcount(vcount), .vsync(vsync),
    .base_addr(base_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Memory: read data for an address is a fixed scramble, valid LAT cycles later.
  function automatic logic [DB-1:0] mdata(input logic [AB-1:0] a);
    return {a[11:0], a} ^ 32'hA5C3_0000;
  endfunction

  logic [AB-1:0] rp_a0 = '0, rp_a1 = '0;
  always @(posedge clk) begin
    rp_a1 <= rp_a0;
    rp_a0 <= mem_addr;
  end
  assign mem_rdata = mdata(rp_a1);

  int n_vec = 0;
  int n_mis = 0;
  int unsigned cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: one fetch job at a time, expected line-buffer writes in a queue.
  typedef struct {
    int unsigned   due;
    logic          bank;
    int            idx;
    logic [AB-1:0] addr;
  } lbw_t;

  lbw_t          lbq[$];
  bit            busy, pause, m_ovr, m_vs;
  int            tail, w;
  logic [31:0]   m_vc;
  logic [AB-1:0] m_fbase, job_addr;
  logic          job_bank;

  task automatic model_reset();
    busy = 0; pause = 0; tail = 0; w = 0; m_ovr = 0;
    m_vc = '0; m_vs = 1'b1; m_fbase = '0; job_addr = '0; job_bank = 1'b0;
    lbq.delete();
  endtask

  task automatic model_cycle();
    logic [31:0]   tgt;
    logic [AB-1:0] base_eff, raddr;
    bit            ev, qual, fall, idle, e_rd, e_wr, e_lb;
    lbw_t          ent;
    tgt      = (vcount == 32'(MAXV)) ? 32'd0 : vcount + 32'd1;
    ev       = (vcount != m_vc);
    qual     = ev && (tgt < 32'(LINES));
    fall     = m_vs && !vsync;
    base_eff = fall ? base_addr : m_fbase;
    idle     = !busy && !pause && (tail == 0);
    e_rd     = busy && !pause;
    e_wr     = (pause || (idle && !qual)) && wr_valid;
    raddr    = AB'(job_addr + AB'(w));

    check_eq("mem_en", mem_en, e_rd || e_wr);
    check_eq("mem_we", mem_we, e_wr);
    check_eq("wr_ready", wr_ready, e_wr);
    if (e_rd) check_eq("rd_addr", mem_addr, raddr);
    if (e_wr) begin
      check_eq("wr_addr", mem_addr, wr_addr);
      check_eq("wr_data", mem_wdata, wr_data);
    end
    while (lbq.size() != 0 && lbq[0].due < cyc) void'(lbq.pop_front());
    e_lb = (lbq.size() != 0) && (lbq[0].due == cyc);
    check_eq("lb_we", lb_we, e_lb);
    if (e_lb) begin
      ent = lbq.pop_front();
      check_eq("lb_addr", lb_addr, 64'(ent.idx));
      check_eq("lb_bank", lb_bank, ent.bank);
      check_eq("lb_wdata", lb_wdata, mdata(ent.addr));
    end
    check_eq("overrun", overrun, m_ovr);

    if (e_rd) lbq.push_back('{due: cyc + LAT, bank: job_bank, idx: w, addr: raddr});
    if (qual) begin
      if (!idle) m_ovr = 1;
      busy = 1; pause = 0; tail = 0; w = 0;
      job_addr = AB'(base_eff + AB'(tgt * W));
      job_bank = tgt[0];
    end else if (pause) begin
      pause = 0;
    end else if (busy) begin
      if (w == W - 1) begin
        busy = 0; tail = LAT;
      end else begin
        if (((w + 1) % BL == 0) && wr_valid) pause = 1;
        w++;
      end
    end else if (tail > 0) begin
      tail--;
    end
    m_vc = vcount;
    m_vs = vsync;
    if (fall) m_fbase = base_addr;
    cyc++;
  endtask

  task automatic step(input logic [31:0] vc, input logic vs, input logic [AB-1:0] base, input logic wv);
    @(posedge clk);
    #1;
    vcount = vc; vsync = vs; base_addr = base; wr_valid = wv;
    wr_addr = AB'($urandom); wr_data = $urandom;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic hold(input logic [31:0] vc, input logic vs, input logic [AB-1:0] base,
                      input logic wv, input int n);
    for (int i = 0; i < n; i++) step(vc, vs, base, wv);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; vcount = '0; vsync = 1'b1; wr_valid = 1'b0;
    #1;
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_lb_we", lb_we, 0);
    check_eq("rst_lb_bank", lb_bank, 0);
    check_eq("rst_overrun", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] vc;
    int          hold_left;
    model_reset();
    apply_reset();

    // Base latched on a vsync fall, then fetch of line 2 from 0x110.
    step(0, 1'b0, 20'h100, 1'b0);
    hold(0, 1'b1, 20'h0, 1'b0, 3);
    hold(1, 1'b1, 20'h0, 1'b0, 14);
    // Frame wrap with a simultaneous vsync fall: line 0 from 0x4000.
    step(749, 1'b0, 20'h4000, 1'b0);
    hold(749, 1'b1, 20'h0, 1'b0, 13);
    // Writer held busy through a fetch.
    hold(2, 1'b1, 20'h0, 1'b1, 16);
    // Last visible line, then lines past the visible area.
    hold(718, 1'b1, 20'h0, 1'b0, 14);
    hold(719, 1'b1, 20'h0, 1'b0, 4);
    hold(720, 1'b1, 20'h0, 1'b0, 6);
    check_eq("no_ovr_invisible", overrun, 0);
    // Line event three cycles into a fetch.
    hold(10, 1'b1, 20'h0, 1'b0, 4);
    hold(11, 1'b1, 20'h0, 1'b0, 14);
    check_eq("overrun_sticky", overrun, 1);
    hold(12, 1'b1, 20'h0, 1'b1, 14);
    // Reset in the middle of a fetch.
    hold(13, 1'b1, 20'h0, 1'b0, 4);
    apply_reset();
    hold(0, 1'b1, 20'h0, 1'b0, 6);

    vc = 32'd100;
    hold_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold_left == 0) begin
        case ($urandom_range(0, 9))
          0: vc = 32'd719;
          1: vc = 32'd749;
          2: vc = 32'd748;
          default: vc = (vc >= 32'(MAXV)) ? 32'd0 : vc + 32'd1;
        endcase
        hold_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(12, 20);
      end
      hold_left--;
      step(vc, ($urandom_range(0, 19) != 0), AB'($urandom), 1'($urandom_range(0, 1)));
      if (i == 1200) apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
